// File: rtl/alu_seq_if.sv
// Operand/handshake/result bundle for alu_seq.
// The remainder signal exists only when ALU_REM_EN is defined.
interface alu_seq_if #(
  parameter int unsigned WIDTH = 4
);
  logic [WIDTH-1:0]   portA;
  logic [WIDTH-1:0]   portB;
  logic [1:0]         opcode;
  logic               start;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] result;
  logic               neg;
  logic               div_by_zero;
`ifdef ALU_REM_EN
  logic [WIDTH-1:0]   remainder;
`endif

  modport master (
    output portA, portB, opcode, start,
    input  busy, done, result, neg, div_by_zero
`ifdef ALU_REM_EN
    , input remainder
`endif
  );

  modport slave (
    input  portA, portB, opcode, start,
    output busy, done, result, neg, div_by_zero
`ifdef ALU_REM_EN
    , output remainder
`endif
  );
endinterface

// File: rtl/alu_seq.sv
// Sequential ALU: add/sub in one step, shift-add multiply and restoring divide one bit per clock.
// Define ALU_REM_EN to build the remainder register and output.
module alu_seq #(
  parameter int unsigned WIDTH = 4
) (
  input logic     clk,
  input logic     rst,
  alu_seq_if.slave bus
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0] CntFull = CntW'(WIDTH);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);

  typedef enum logic [1:0] {OpAdd = 2'b00, OpSub = 2'b01, OpMul = 2'b10, OpDiv = 2'b11} op_e;
  typedef enum logic [1:0] {StIdle, StRun, StFin} state_e;

  state_e             state_q, state_d;
  op_e                op_q;
  logic [WIDTH-1:0]   a_q, b_q, shift_q, shift_nx;
  logic [2*WIDTH-1:0] acc_q, acc_nx, mcand_q, result_q, result_d;
  logic [CntW-1:0]    cnt_q;
  logic               neg_q, neg_d, dbz_q, dbz_d;
  logic               load, step, fin;
  logic [WIDTH:0]     sum, rem_sh;
  logic [WIDTH-1:0]   rem_sub;
  logic               ge, b_zero;
`ifdef ALU_REM_EN
  logic [WIDTH-1:0]   rem_q, rem_d;
`endif

  // Datapath: one iteration step plus the value each opcode would commit at FIN.
  always_comb begin
    sum      = {1'b0, a_q} + {1'b0, b_q};
    b_zero   = (b_q == '0);
    rem_sh   = {acc_q[WIDTH-1:0], shift_q[WIDTH-1]};
    ge       = (rem_sh >= {1'b0, b_q});
    rem_sub  = rem_sh[WIDTH-1:0] - b_q;
    acc_nx   = acc_q;
    shift_nx = shift_q;
    if (op_q == OpMul) begin
      acc_nx   = shift_q[0] ? acc_q + mcand_q : acc_q;
      shift_nx = shift_q >> 1;
    end else begin
      // Divide: acc low half is the partial remainder, shift_q trades dividend for quotient bits.
      acc_nx   = {{WIDTH{1'b0}}, (ge ? rem_sub : rem_sh[WIDTH-1:0])};
      shift_nx = {shift_q[WIDTH-2:0], ge};
    end

    result_d = '0;
    neg_d    = 1'b0;
    dbz_d    = 1'b0;
`ifdef ALU_REM_EN
    rem_d    = '0;
`endif
    unique case (op_q)
      OpAdd: result_d = {{(WIDTH-1){1'b0}}, sum};
      OpSub: begin
        neg_d    = (b_q > a_q);
        result_d = {{WIDTH{1'b0}}, (neg_d ? b_q - a_q : a_q - b_q)};
      end
      OpMul: result_d = acc_nx;
      OpDiv: begin
        if (b_zero) begin
          result_d = {{WIDTH{1'b0}}, {WIDTH{1'b1}}};
          dbz_d    = 1'b1;
`ifdef ALU_REM_EN
          rem_d    = a_q;
`endif
        end else begin
          result_d = {{WIDTH{1'b0}}, shift_nx};
`ifdef ALU_REM_EN
          rem_d    = acc_nx[WIDTH-1:0];
`endif
        end
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    fin     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          load    = 1'b1;
          state_d = StRun;
        end
      end
      StRun: begin
        unique case (op_q)
          OpAdd, OpSub: fin = 1'b1;
          OpMul: begin
            step = 1'b1;
            fin  = (cnt_q == CntOne);
          end
          OpDiv: begin
            if (b_zero) begin
              fin = 1'b1;
            end else begin
              step = 1'b1;
              fin  = (cnt_q == CntOne);
            end
          end
        endcase
        if (fin) state_d = StFin;
      end
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      op_q     <= OpAdd;
      a_q      <= '0;
      b_q      <= '0;
      shift_q  <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      neg_q    <= 1'b0;
      dbz_q    <= 1'b0;
`ifdef ALU_REM_EN
      rem_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      if (load) begin
        op_q    <= op_e'(bus.opcode);
        a_q     <= bus.portA;
        b_q     <= bus.portB;
        acc_q   <= '0;
        mcand_q <= {{WIDTH{1'b0}}, bus.portA};
        shift_q <= (bus.opcode == OpMul) ? bus.portB : bus.portA;
        cnt_q   <= (bus.opcode[1]) ? CntFull : CntOne;
      end else if (step) begin
        acc_q   <= acc_nx;
        mcand_q <= mcand_q << 1;
        shift_q <= shift_nx;
        cnt_q   <= cnt_q - CntOne;
      end
      if (fin) begin
        result_q <= result_d;
        neg_q    <= neg_d;
        dbz_q    <= dbz_d;
`ifdef ALU_REM_EN
        rem_q    <= rem_d;
`endif
      end
    end
  end

  assign bus.busy        = (state_q != StIdle);
  assign bus.done        = (state_q == StFin);
  assign bus.result      = result_q;
  assign bus.neg         = neg_q;
  assign bus.div_by_zero = dbz_q;
`ifdef ALU_REM_EN
  assign bus.remainder   = rem_q;
`endif

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised sequential successor of the lab ALU: WIDTH-bit unsigned operands, four opcodes (add, sub, mul, div), start/busy/done handshake.
- Multiply is iterative shift-add; divide is iterative restoring division, one bit per clock.
- Sits between the switch/operand inputs and the display driver; the wide result feeds the BCD/seven-segment path.

Parameters:
- WIDTH, 4, operand width in bits (legal 2..16); result is 2*WIDTH bits.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- portA  in  WIDTH  operand A (minuend / multiplicand / dividend).
- portB  in  WIDTH  operand B (subtrahend / multiplier / divisor).
- opcode  in  2  00 add, 01 sub, 10 mul, 11 div.
- start  in  1  request; sampled only in IDLE.
- busy  out  1  high while an operation is in progress.
- done  out  1  single-cycle pulse when result/flags update.
- result  out  2*WIDTH  sum, |difference|, product, or quotient (zero-extended).
- neg  out  1  sub only: 1 when B > A.
- div_by_zero  out  1  div only: 1 when B == 0.
- remainder  out  WIDTH  division remainder (present only with ALU_REM_EN).

Behaviour:
- Reset (rst=0, async): state IDLE; result, remainder, neg, div_by_zero, busy, done, counter all 0.
- States: IDLE, RUN, FIN.
- IDLE: on start=1, latch portA, portB, opcode into internal registers, load counter, go to RUN; busy=1 from the next cycle.
- Later changes on portA/portB/opcode have no effect until the next accepted start.
- RUN, add/sub: one cycle, then FIN.
  - add: result = A + B (WIDTH+1 significant bits, carry kept).
  - sub: result = |A - B|; neg = (B > A).
- RUN, mul: WIDTH cycles of shift-add (examine B LSB, add A shifted into accumulator), then FIN. result = A*B exact.
- RUN, div: WIDTH cycles of restoring division (shift remainder left, bring in dividend MSB, trial subtract B, restore if negative), then FIN.
  - result = floor(A/B); remainder = A mod B.
- Div by zero: detected in the first RUN cycle; goes directly to FIN.
  - result = all ones in low WIDTH bits, upper bits 0; remainder = A; div_by_zero=1.
- FIN: result and flags registered; done=1 for exactly this cycle; busy=0 on the next cycle; return to IDLE.
- Flags not relevant to the current opcode are cleared at FIN.
- Latency from the start-sampling edge to the done-high cycle:
  - add/sub: 2 cycles.
  - mul/div: WIDTH+1 cycles.
  - div by zero: 2 cycles.
- result/flags hold their value until the next FIN or reset.
- start while busy (RUN or FIN): ignored, no queuing.
- start held high continuously: a new operation is accepted on the first IDLE cycle after FIN.
- Reset asserted mid-operation: immediate abort, all outputs 0, no done pulse.

Optional Feature:
- ALU_REM_EN defined: remainder port exists and is updated as above (0 for non-div ops).
- ALU_REM_EN not defined: port absent, remainder register not synthesised; quotient, div_by_zero and timing unchanged.

Test Plan (WIDTH=4):
- add: A=7, B=9, start -> 2 cycles later done=1, result=0x10, neg=0; busy low next cycle.
- sub: A=3, B=9 -> result=6, neg=1; then A=9, B=3 -> result=6, neg=0.
- mul: A=15, B=15 -> done exactly 5 cycles after start edge, result=225 (0xE1); busy high for cycles 1-5 only.
- div: A=13, B=4 -> result=3, remainder=1 (ALU_REM_EN), done at 5 cycles; A=9, B=0 -> done at 2 cycles, result=0x0F, remainder=9, div_by_zero=1.
- robustness: start pulsed again while busy on mul 6*7 -> ignored, result=42; change portA mid-run -> result still 42.
- reset: rst low 3 cycles into a div -> all outputs 0 immediately, no done; after release a new add 1+1 -> result=2.
